cordic_vector: RTL and testbench
================================

CORDIC_VECTOR -- requirements
Module: cordic_vector

Interface
REQ-001 SHALL have parameter WIDTH, default 16, data width of inputs and outputs.
REQ-002 SHALL have parameter ITERATIONS, default 16, number of micro-rotations.
REQ-003 SHALL have parameter FRAC_BITS, default 14, fractional bits of x_in, y_in and mag_out.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-006 SHALL have port start  input  1  request; sampled only in IDLE.
REQ-007 SHALL have port x_in  input  WIDTH  signed Q2.14 x coordinate.
REQ-008 SHALL have port y_in  input  WIDTH  signed Q2.14 y coordinate.
REQ-009 SHALL have port mag_out  output  WIDTH  unsigned-valued Q2.14 sqrt(x²+y²), gain-compensated.
REQ-010 SHALL have port angle_out  output  WIDTH  signed Q3.13 atan2(y,x) in radians, range (-pi, +pi].
REQ-011 SHALL have port busy  output  1  high while a conversion is in progress.
REQ-012 SHALL have port done  output  1  one-cycle pulse; outputs valid.

Function
REQ-013 SHALL implement FSM IDLE -> PRE -> CALC -> SCALE -> IDLE; no other states.
REQ-014 IDLE with start=1 at edge k SHALL latch x_in/y_in, enter PRE and set busy.
REQ-015 PRE SHALL pre-rotate: x>=0: (x,y,z)=(x,y,0); x<0,y>=0: (y,-x,+pi/2); x<0,y<0: (-y,x,-pi/2).
REQ-016 CALC SHALL do one micro-rotation per cycle for i=0..ITERATIONS-1: y>=0: x+=y>>>i, y-=x>>>i, z+=atan[i]; else x-=y>>>i, y+=x>>>i, z-=atan[i].
REQ-017 x/y datapath SHALL be WIDTH+2 bits signed with arithmetic shifts; z SHALL be WIDTH bits Q3.13.
REQ-018 SCALE SHALL compute mag = x*K, K=0x26DD (0.607253, Q2.14), round half-up at bit FRAC_BITS, saturate to [0, 2^(WIDTH-1)-1].
REQ-019 done SHALL be high exactly in the cycle after edge k+18 (PRE 1, CALC 16, SCALE 1); busy SHALL drop at the same edge done rises.
REQ-020 mag_out/angle_out SHALL update only with done and hold until the next done.
REQ-021 start while busy SHALL be ignored; start in the done cycle SHALL be accepted (back-to-back).
REQ-022 (0,0) SHALL yield mag_out=0, angle_out=0.
REQ-023 y=0, x<0 SHALL yield angle_out=+pi (0x6488), never -pi.

Reset
REQ-024 rst SHALL force state IDLE, busy=0, done=0, mag_out=0, angle_out=0 at the next edge.
REQ-025 rst mid-conversion SHALL abort with no done pulse; the next start SHALL run normally.
REQ-026 rst SHALL take priority over start on the same edge.

Structure
REQ-027 Shared package cordic_pkg SHALL hold FRAC_BITS, atan table (Q3.13, atan[0]=0x1922), K=0x26DD, PI=0x6488, PI_2=0x3244, FSM state encoding.
REQ-028 The rotation-mode CORDIC block SHALL migrate to cordic_pkg constants.
REQ-029 One sub-module cordic_microrot (combinational single-iteration add/shift/z update, direction input) SHALL be instantiated once.

Verification
REQ-030 x=0x4000, y=0x0000 -> mag_out 0x4000±4, angle_out 0x0000±4, done at start edge+19.
REQ-031 x=0x4000, y=0x4000 -> mag_out 0x5A82±4, angle_out 0x1922±4.
REQ-032 x=0xC000, y=0x0000 -> mag_out 0x4000±4, angle_out 0x6488±4; x=0x0000, y=0xC000 -> angle_out 0xCDBC±4.
REQ-033 x=0x8000, y=0x8000 -> mag_out 0x7FFF (saturated), angle_out 0xB49A±4; x=y=0 -> both 0.
REQ-034 start pulsed during CALC -> ignored, single done; start held high -> back-to-back conversions 19 cycles apart.
REQ-035 rst at 5th CALC cycle -> no done, outputs 0, busy 0; next start x=0x4000,y=0 -> correct result.

Source files
------------

// File: rtl/cordic_pkg.sv
// cordic_pkg: shared constants for the CORDIC blocks.
//   FRAC_BITS    - fractional bits of the Q2.14 coordinate/magnitude format
//   CORDIC_K     - CORDIC gain compensation 0.607253 in Q2.14
//   CORDIC_PI    - pi in Q3.13
//   CORDIC_PI_2  - pi/2 in Q3.13
//   state_t      - vectoring FSM state encoding
//   atan_lut()   - atan(2^-i) in Q3.13, i = 0..15
package cordic_pkg;

  localparam int          FRAC_BITS   = 14;
  localparam logic [15:0] CORDIC_K    = 16'h26DD;
  localparam logic [15:0] CORDIC_PI   = 16'h6488;
  localparam logic [15:0] CORDIC_PI_2 = 16'h3244;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRE   = 2'd1,
    ST_CALC  = 2'd2,
    ST_SCALE = 2'd3
  } state_t;

  function automatic logic [15:0] atan_lut(input int unsigned idx);
    logic [15:0] v;
    case (idx)
      0:       v = 16'h1922;
      1:       v = 16'h0ED6;
      2:       v = 16'h07D7;
      3:       v = 16'h03FB;
      4:       v = 16'h01FF;
      5:       v = 16'h0100;
      6:       v = 16'h0080;
      7:       v = 16'h0040;
      8:       v = 16'h0020;
      9:       v = 16'h0010;
      10:      v = 16'h0008;
      11:      v = 16'h0004;
      12:      v = 16'h0002;
      13:      v = 16'h0001;
      default: v = 16'h0000;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/cordic_microrot.sv
// cordic_microrot: one combinational CORDIC micro-rotation.
//   i_x, i_y  - current vector (XW-bit signed)
//   i_z       - current angle accumulator (ZW-bit signed)
//   i_atan    - atan(2^-i) for this iteration
//   i_shift   - iteration index i (shift amount)
//   i_dir     - 1: y >= 0 (rotate clockwise, add angle); 0: rotate counter-clockwise
//   o_x/o_y/o_z - rotated vector and updated angle
module cordic_microrot #(
  parameter int XW = 18,
  parameter int ZW = 16,
  parameter int SW = 4
) (
  input  logic signed [XW-1:0] i_x,
  input  logic signed [XW-1:0] i_y,
  input  logic signed [ZW-1:0] i_z,
  input  logic signed [ZW-1:0] i_atan,
  input  logic        [SW-1:0] i_shift,
  input  logic                 i_dir,
  output logic signed [XW-1:0] o_x,
  output logic signed [XW-1:0] o_y,
  output logic signed [ZW-1:0] o_z
);

  logic signed [XW-1:0] w_xs;
  logic signed [XW-1:0] w_ys;

  assign w_xs = i_x >>> i_shift;
  assign w_ys = i_y >>> i_shift;

  always_comb begin
    if (i_dir) begin
      o_x = i_x + w_ys;
      o_y = i_y - w_xs;
      o_z = i_z + i_atan;
    end else begin
      o_x = i_x - w_ys;
      o_y = i_y + w_xs;
      o_z = i_z - i_atan;
    end
  end

endmodule

// File: rtl/cordic_vector.sv
// cordic_vector: multi-cycle vectoring-mode CORDIC (cartesian -> polar).
//   clk       - clock, rising edge
//   rst       - synchronous active-high reset
//   start     - conversion request, sampled only while idle
//   x_in/y_in - signed Q2.14 coordinates
//   mag_out   - Q2.14 magnitude, gain-compensated, saturated to [0, 2^(WIDTH-1)-1]
//   angle_out - Q3.13 atan2(y,x), range (-pi, +pi]
//   busy      - conversion in progress
//   done      - one-cycle pulse when mag_out/angle_out are updated
module cordic_vector #(
  parameter int WIDTH      = 16,
  parameter int ITERATIONS = 16,
  parameter int FRAC_BITS  = cordic_pkg::FRAC_BITS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] x_in,
  input  logic [WIDTH-1:0] y_in,
  output logic [WIDTH-1:0] mag_out,
  output logic [WIDTH-1:0] angle_out,
  output logic             busy,
  output logic             done
);

  import cordic_pkg::*;

  localparam int XW = WIDTH + 2;
  localparam int SW = (ITERATIONS > 1) ? $clog2(ITERATIONS) : 1;
  localparam int PW = XW + WIDTH;

  localparam logic signed [WIDTH-1:0] PI_S     = WIDTH'(CORDIC_PI);
  localparam logic signed [WIDTH-1:0] ANG_MIN  = WIDTH'(1 - int'(CORDIC_PI));
  localparam logic signed [WIDTH-1:0] PI_2_S   = WIDTH'(CORDIC_PI_2);
  localparam logic signed [WIDTH-1:0] NEG_PI_2 = WIDTH'(-int'(CORDIC_PI_2));
  localparam logic signed [PW-1:0]    MAG_MAX  = PW'((64'sd1 <<< (WIDTH - 1)) - 64'sd1);
  localparam logic signed [PW-1:0]    ROUND    = PW'(64'sd1 <<< (FRAC_BITS - 1));
  localparam logic signed [PW-1:0]    K_S      = $signed(PW'(CORDIC_K));

  state_t r_state;
  state_t w_state_next;

  logic signed [XW-1:0]    r_x;
  logic signed [XW-1:0]    r_y;
  logic signed [WIDTH-1:0] r_z;
  logic        [SW-1:0]    r_iter;
  logic                    r_zero;
  logic                    r_done;
  logic        [WIDTH-1:0] r_mag;
  logic        [WIDTH-1:0] r_ang;

  logic signed [XW-1:0]    w_x_rot;
  logic signed [XW-1:0]    w_y_rot;
  logic signed [WIDTH-1:0] w_z_rot;
  logic signed [WIDTH-1:0] w_atan;
  logic signed [PW-1:0]    w_prod;
  logic signed [PW-1:0]    w_scaled;
  logic        [WIDTH-1:0] w_mag_sat;
  logic        [WIDTH-1:0] w_ang_sat;

  assign w_atan = $signed(WIDTH'(atan_lut(32'(r_iter))));

  cordic_microrot #(
    .XW(XW),
    .ZW(WIDTH),
    .SW(SW)
  ) u_microrot (
    .i_x    (r_x),
    .i_y    (r_y),
    .i_z    (r_z),
    .i_atan (w_atan),
    .i_shift(r_iter),
    .i_dir  (~r_y[XW-1]),
    .o_x    (w_x_rot),
    .o_y    (w_y_rot),
    .o_z    (w_z_rot)
  );

  // Gain compensation with round-half-up, then clamp into the unsigned range.
  assign w_prod   = PW'(r_x) * K_S;
  assign w_scaled = (w_prod + ROUND) >>> FRAC_BITS;

  always_comb begin
    w_mag_sat = w_scaled[WIDTH-1:0];
    if (w_scaled < 0) begin
      w_mag_sat = '0;
    end else if (w_scaled > MAG_MAX) begin
      w_mag_sat = MAG_MAX[WIDTH-1:0];
    end
  end

  // A zero vector never converges (z just sums the table), so it is forced to 0.
  // Residual error near the negative real axis is folded into (-pi, +pi].
  always_comb begin
    w_ang_sat = r_z;
    if (r_zero) begin
      w_ang_sat = '0;
    end else if (r_z > PI_S) begin
      w_ang_sat = PI_S;
    end else if (r_z < ANG_MIN) begin
      w_ang_sat = ANG_MIN;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_state_next = ST_PRE;
      ST_PRE:   w_state_next = ST_CALC;
      ST_CALC:  if (r_iter == SW'(ITERATIONS - 1)) w_state_next = ST_SCALE;
      ST_SCALE: w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_x    <= '0;
      r_y    <= '0;
      r_z    <= '0;
      r_iter <= '0;
      r_zero <= 1'b0;
      r_done <= 1'b0;
      r_mag  <= '0;
      r_ang  <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_x    <= XW'($signed(x_in));
            r_y    <= XW'($signed(y_in));
            r_zero <= (x_in == '0) && (y_in == '0);
          end
        end
        ST_PRE: begin
          // Fold the left half-plane into the right so CORDIC converges.
          r_iter <= '0;
          if (!r_x[XW-1]) begin
            r_z <= '0;
          end else if (!r_y[XW-1]) begin
            r_x <= r_y;
            r_y <= -r_x;
            r_z <= PI_2_S;
          end else begin
            r_x <= -r_y;
            r_y <= r_x;
            r_z <= NEG_PI_2;
          end
        end
        ST_CALC: begin
          r_x    <= w_x_rot;
          r_y    <= w_y_rot;
          r_z    <= w_z_rot;
          r_iter <= r_iter + SW'(1);
        end
        ST_SCALE: begin
          r_mag  <= w_mag_sat;
          r_ang  <= w_ang_sat;
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy      = (r_state != ST_IDLE);
  assign done      = r_done;
  assign mag_out   = r_mag;
  assign angle_out = r_ang;

endmodule

// File: tb/tb_cordic_vector.sv
module tb_cordic_vector;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] x_in;
  logic [W-1:0] y_in;
  logic [W-1:0] mag_out;
  logic [W-1:0] angle_out;
  logic         busy;
  logic         done;

  int n_vec    = 0;
  int n_err    = 0;
  int prev_m   = 0;
  int prev_a   = 0;
  int prev_tol = 0;

  always #5 clk = ~clk;

  cordic_vector #(
    .WIDTH(16),
    .ITERATIONS(16),
    .FRAC_BITS(14)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .x_in     (x_in),
    .y_in     (y_in),
    .mag_out  (mag_out),
    .angle_out(angle_out),
    .busy     (busy),
    .done     (done)
  );

  function automatic int s16(input logic [15:0] v);
    return int'($signed(v));
  endfunction

  function automatic int absmax(input logic [15:0] a, input logic [15:0] b);
    int ia, ib;
    ia = s16(a); if (ia < 0) ia = -ia;
    ib = s16(b); if (ib < 0) ib = -ib;
    return (ia > ib) ? ia : ib;
  endfunction

  // Reference: ideal polar conversion with real arithmetic.
  function automatic int model_mag(input logic [15:0] x, input logic [15:0] y);
    real xr, yr;
    int  m;
    xr = real'(s16(x));
    yr = real'(s16(y));
    m  = int'($sqrt(xr * xr + yr * yr));
    if (m > 32767) m = 32767;
    return m;
  endfunction

  function automatic int model_ang(input logic [15:0] x, input logic [15:0] y);
    int a;
    if (x == 16'h0 && y == 16'h0) return 0;
    a = int'($atan2(real'(s16(y)), real'(s16(x))) * 8192.0);
    if (a > 25736)  a = 25736;
    if (a < -25735) a = -25735;
    return a;
  endfunction

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_tol(input string tag, input int obs, input int exp, input int tol);
    int diff;
    diff = obs - exp;
    if (diff < 0) diff = -diff;
    assert ((diff <= tol) === 1'b1) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d +/- %0d", tag, obs, exp, tol);
    end
  endtask

  // One conversion: start at the next edge k, done expected after edge k+18.
  task automatic run_conv(input logic [15:0] x, input logic [15:0] y,
                          input int exp_m, input int exp_a, input int tol,
                          input bit inject);
    int early;
    x_in  = x;
    y_in  = y;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    n_vec++;
    chk_bit("busy_set", busy, 1'b1);
    early = 0;
    for (int e = 1; e <= 18; e++) begin
      @(negedge clk);
      if (inject && e == 5) begin
        start = 1'b1;
        x_in  = 16'h2000;
        y_in  = 16'h6000;
      end
      if (inject && e == 6) start = 1'b0;
      if (e < 18 && done) early++;
      if (e == 17) begin
        chk_tol("hold_mag_before_done", int'(mag_out), prev_m, prev_tol);
        chk_tol("hold_ang_before_done", s16(angle_out), prev_a, prev_tol);
      end
    end
    chk_bit("done_at_k18", done, 1'b1);
    chk_bit("busy_clr_at_done", busy, 1'b0);
    chk_tol("early_done", early, 0, 0);
    chk_tol("mag", int'(mag_out), exp_m, tol);
    chk_tol("ang", s16(angle_out), exp_a, tol);
    $display("conv x=%h y=%h -> mag=%h ang=%h (exp mag=%0d ang=%0d)",
             x, y, mag_out, angle_out, exp_m, exp_a);
    @(negedge clk);
    chk_bit("done_one_cycle", done, 1'b0);
    chk_tol("mag_hold_after_done", int'(mag_out), exp_m, tol);
    prev_m   = exp_m;
    prev_a   = exp_a;
    prev_tol = tol;
  endtask

  initial begin
    logic [15:0] rx, ry;
    int extra, d1, d2, nd;

    rst   = 1'b1;
    start = 1'b0;
    x_in  = '0;
    y_in  = '0;
    repeat (3) @(negedge clk);
    chk_bit("rst_busy", busy, 1'b0);
    chk_bit("rst_done", done, 1'b0);
    chk_tol("rst_mag", int'(mag_out), 0, 0);
    chk_tol("rst_ang", s16(angle_out), 0, 0);
    rst = 1'b0;
    @(negedge clk);

    // Directed points
    run_conv(16'h4000, 16'h0000, 16'h4000, 0, 4, 1'b0);
    run_conv(16'h4000, 16'h4000, 16'h5A82, 16'h1922, 4, 1'b0);
    run_conv(16'hC000, 16'h0000, 16'h4000, 16'h6488, 4, 1'b0);
    run_conv(16'h0000, 16'hC000, 16'h4000, s16(16'hCDBC), 4, 1'b0);
    run_conv(16'h8000, 16'h8000, 16'h7FFF, s16(16'hB49A), 4, 1'b0);
    run_conv(16'h0000, 16'h0000, 0, 0, 0, 1'b0);

    // start pulsed during CALC must be ignored
    run_conv(16'h2D41, 16'hD2BF, model_mag(16'h2D41, 16'hD2BF),
             model_ang(16'h2D41, 16'hD2BF), 4, 1'b1);
    extra = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (done) extra++;
    end
    chk_tol("no_second_done", extra, 0, 0);

    // start held high: back-to-back conversions 19 cycles apart
    x_in  = 16'h4000;
    y_in  = 16'h0000;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_vec += 2;
    d1 = -1; d2 = -1; nd = 0;
    for (int e = 1; e <= 40; e++) begin
      @(negedge clk);
      if (done) begin
        nd++;
        if (d1 < 0) d1 = e;
        else if (d2 < 0) d2 = e;
      end
      if (e == 37) start = 1'b0;
    end
    chk_tol("b2b_first_done", d1, 18, 0);
    chk_tol("b2b_second_done", d2, 37, 0);
    chk_tol("b2b_done_count", nd, 2, 0);
    chk_tol("b2b_mag", int'(mag_out), 16'h4000, 4);
    $display("b2b x=4000 y=0000 -> done at +%0d and +%0d, mag=%h", d1, d2, mag_out);
    prev_m = 16'h4000; prev_a = 0; prev_tol = 4;

    // Reset in the 5th CALC cycle aborts the conversion
    x_in  = 16'h4000;
    y_in  = 16'h4000;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    n_vec++;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_bit("abort_busy", busy, 1'b0);
    chk_bit("abort_done", done, 1'b0);
    chk_tol("abort_mag", int'(mag_out), 0, 0);
    chk_tol("abort_ang", s16(angle_out), 0, 0);
    rst = 1'b0;
    extra = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (done) extra++;
    end
    chk_tol("abort_no_done", extra, 0, 0);
    $display("abort x=4000 y=4000 -> rst mid-CALC, busy=%b mag=%h", busy, mag_out);
    prev_m = 0; prev_a = 0; prev_tol = 0;
    run_conv(16'h4000, 16'h0000, 16'h4000, 0, 4, 1'b0);

    // rst wins over start on the same edge
    rst   = 1'b1;
    start = 1'b1;
    x_in  = 16'h4000;
    y_in  = 16'h4000;
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    n_vec++;
    chk_bit("rst_over_start_busy", busy, 1'b0);
    @(negedge clk);
    chk_bit("rst_over_start_idle", busy, 1'b0);
    $display("rst+start same edge -> busy=%b", busy);
    prev_m = 0; prev_a = 0; prev_tol = 0;

    // Randomized vectors against the real-arithmetic model
    for (int i = 0; i < 40; i++) begin
      do begin
        rx = 16'($urandom);
        ry = 16'($urandom);
      end while (absmax(rx, ry) < 32'h2000);
      run_conv(rx, ry, model_mag(rx, ry), model_ang(rx, ry), 8, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
